// File: rtl/load_align_unit.sv
// Load unit for the memory stage: word reads, byte/half extraction, sign/zero extension.
// Latency: single read 2+L cycles to rsp_valid, crossing read 3+2L, address error 1 cycle.
// Backpressure: one request in flight; req_ready is low until the response is taken.
module load_align_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter bit ALLOW_UNALIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_op,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_exc,
  input  logic                  rsp_ready
);

  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  // Latched request context, held for the whole transaction.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            op;
  } req_ctx_t;

  state_t      state;
  req_ctx_t    ctx_q;
  logic [31:0] w0_q;
  logic        req_misaligned;
  logic        ctx_crosses;

  // Shift the two-word window down to the addressed byte, then extend per load type.
  function automatic logic [31:0] assemble(input logic [63:0] pair,
                                           input logic [1:0]  off,
                                           input logic [2:0]  op);
    logic [63:0] sh;
    logic [31:0] res;
    sh = pair >> {off, 3'b000};
    case (op)
      OP_LB:   res = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  res = {24'h0, sh[7:0]};
      OP_LH:   res = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  res = {16'h0, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  // Acceptance is only possible in IDLE and never while reset is asserted.
  assign req_ready = (state == IDLE) && !reset;

  // Alignment of the incoming request: bytes always fine, halves need even, words need 00.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_op)
      OP_LB, OP_LBU: req_misaligned = 1'b0;
      OP_LH, OP_LHU: req_misaligned = req_addr[0];
      default:       req_misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  // Whether the latched access spills into the next word and needs a second read.
  always_comb begin
    ctx_crosses = 1'b0;
    case (ctx_q.op)
      OP_LB, OP_LBU: ctx_crosses = 1'b0;
      OP_LH, OP_LHU: ctx_crosses = (ctx_q.addr[1:0] == 2'b11);
      default:       ctx_crosses = (ctx_q.addr[1:0] != 2'b00);
    endcase
  end

  // Transaction FSM; all memory-side and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ctx_q       <= '0;
      w0_q        <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_exc     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ctx_q.addr <= req_addr;
            ctx_q.op   <= req_op;
            if (req_misaligned && !ALLOW_UNALIGNED) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_exc   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state       <= RD0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end
        RD0: begin
          mem_rd_en <= 1'b0;
          // Data cannot legally return in the strobe cycle, so it is ignored there.
          if (!mem_rd_en && mem_rd_valid) begin
            w0_q <= mem_rd_data;
            if (ctx_crosses) begin
              state       <= RD1;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(4);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_exc   <= 1'b0;
              rsp_data  <= assemble({32'h0, mem_rd_data}, ctx_q.addr[1:0], ctx_q.op);
            end
          end
        end
        RD1: begin
          mem_rd_en <= 1'b0;
          if (!mem_rd_en && mem_rd_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_exc   <= 1'b0;
            rsp_data  <= assemble({mem_rd_data, w0_q}, ctx_q.addr[1:0], ctx_q.op);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Multi-cycle load unit for the memory stage: accepts a load request (address plus load type), issues word-aligned reads to data memory, extracts and sign/zero-extends the addressed byte/halfword/word, and returns the result over a valid/ready handshake. It generalises the combinational lb/lh/lw extender with three additions: unsigned variants, address-error detection, and optional two-beat support for loads that cross a word boundary. It sits between the M-stage address path and the W-stage register write, against a data memory with variable read latency.

## Interface
- `ADDR_WIDTH`, 32: byte-address width.
- `ALLOW_UNALIGNED`, 0:
  - 0: misaligned loads raise an address error.
  - 1: misaligned loads are serviced, using two reads when the access crosses a word boundary.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  load request valid.
- `req_ready`  out  1  unit can accept a request.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_op`  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu. Other codes are treated as lw.
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_rd_addr`  out  ADDR_WIDTH  word address, with bits [1:0] = 00.
- `mem_rd_data`  in  32  read word, little-endian: byte 0 is [7:0].
- `mem_rd_valid`  in  1  read data valid, arriving L ≥ 1 cycles after `mem_rd_en`.
- `rsp_valid`  out  1  result valid.
- `rsp_data`  out  32  extended load result.
- `rsp_exc`  out  1  address error (AdEL).
- `rsp_ready`  in  1  consumer accepts result.

## Operation
- **States:** IDLE, RD0, RD1, RESP.
- **IDLE:**
  - `req_ready` = 1 in IDLE only; it is 0 in every other state and while `reset` is high.
  - On `req_valid & req_ready`, latch `req_addr` and `req_op`.
- **Misalignment rules:**
  - lw is misaligned if addr[1:0] ≠ 00.
  - lh/lhu are misaligned if addr[0] = 1.
  - lb/lbu are never misaligned.
- **Crossing rules:**
  - lw crosses a word boundary if addr[1:0] ≠ 00.
  - lh/lhu cross a word boundary if addr[1:0] = 11.
- **Transitions out of IDLE on acceptance:**
  - Misaligned and `ALLOW_UNALIGNED`=0 → RESP with `rsp_exc`=1 and `rsp_data`=0. No memory read is issued.
  - Otherwise → RD0.
- **RD0:**
  - Pulse `mem_rd_en` for the first cycle in RD0 only, with `mem_rd_addr` = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Wait for `mem_rd_valid`, then capture `mem_rd_data` as w0.
  - If the access crosses a word boundary → RD1; else → RESP.
- **RD1:**
  - Pulse `mem_rd_en` for the first cycle in RD1 only, with `mem_rd_addr` = previous word address + 4. The address wraps modulo 2^ADDR_WIDTH.
  - On `mem_rd_valid`, capture w1 → RESP.
- **Assembly:**
  - Form a 64-bit value {w1, w0}, where w1 = 0 for single reads.
  - Shift it right by 8·addr[1:0] and take the low bits.
  - lb: sign-extend bits [7:0]. lbu: zero-extend bits [7:0].
  - lh: sign-extend bits [15:0]. lhu: zero-extend bits [15:0].
  - lw: take bits [31:0].
- **RESP:**
  - `rsp_valid` = 1, with `rsp_data` and `rsp_exc` held stable until `rsp_ready`.
  - On `rsp_ready` → IDLE, and `rsp_valid` falls on the next cycle.
- **Ignored input:** `mem_rd_valid` is ignored in IDLE and RESP, and in RD0/RD1 during the same cycle as the strobe.
- **Reset:**
  - Every state returns to IDLE.
  - Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_exc`=0, `mem_rd_en`=0, `mem_rd_addr`=0.
  - A reset mid-RD0/RD1 abandons the outstanding read. Data memory shares `reset`, so no stale `mem_rd_valid` follows.

## Timing
- Let T be the acceptance edge and L the memory latency.
- **Single read:**
  - `mem_rd_en` is high in cycle T+1.
  - `mem_rd_valid` arrives in cycle T+1+L.
  - `rsp_valid` is high from cycle T+2+L.
- **Two reads:**
  - The first `mem_rd_en` is in T+1.
  - The second `mem_rd_en` is in T+2+L.
  - `rsp_valid` is high from T+3+2L.
- **Address error:** `rsp_valid` is high in T+1, and `mem_rd_en` never asserts.
- **Throughput:** at most one outstanding request. The next acceptance is no earlier than the cycle after the `rsp_valid & rsp_ready` handshake.
- **Registered outputs:** `rsp_*`, `mem_rd_en` and `mem_rd_addr` are registered. `req_ready` is decoded from state and `reset` only.

## Test plan
Memory contents: mem[0x10] = 0xDEADBEEF, mem[0x14] = 0x11223344. Latency L = 1 unless stated.

1. **Aligned lw:** lw 0x10 → one `mem_rd_en` with address 0x10 in T+1; `rsp_data` = 0xDEADBEEF, `rsp_exc` = 0, `rsp_valid` in T+3.
2. **Extension modes:**
   - lb 0x13 → 0xFFFFFFDE.
   - lbu 0x13 → 0x000000DE.
   - lh 0x12 → 0xFFFFDEAD.
   - lhu 0x10 → 0x0000BEEF.
   - lb 0x14 → 0x00000044.
3. **`ALLOW_UNALIGNED`=0:**
   - lw 0x11 → `rsp_exc` = 1, `rsp_data` = 0, `rsp_valid` in T+1, no `mem_rd_en`.
   - lh 0x13 → the same response.
4. **`ALLOW_UNALIGNED`=1, L = 3:**
   - lw 0x11 → reads 0x10 then 0x14 (second strobe in T+5); `rsp_data` = 0x44DEADBE; `rsp_valid` in T+9.
   - lh 0x13 → 0x000044DE.
   - lh 0x11 → single read, 0xFFFFADBE.
5. **Backpressure:** hold `rsp_ready` = 0 for 3 cycles → `rsp_valid`, `rsp_data` and `rsp_exc` stay stable and `req_ready` = 0; release `rsp_ready` → IDLE, then a new request is accepted.
6. **Reset mid-operation:** assert `reset` in RD0 before `mem_rd_valid` → next cycle all outputs are at reset values; after `reset` is released, `req_ready` = 1 and lw 0x14 returns 0x11223344.
